// File: rtl/jk_pkg.sv
// Shared definitions for the JK-flip-flop based modulo counter.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_UP     = 2'b01;
  localparam logic [1:0] JK_DOWN   = 2'b10;
  localparam logic [1:0] JK_DIRECT = 2'b11;

endpackage

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH edge-triggered JK flip-flops with synchronous active-high reset.
module jk_ff_bank #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // Per-bit JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= (j & ~q) | (~k & q);
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo up/down/direct-JK counter built on a JK flip-flop bank, with
// parallel load, combinational terminal count and a registered wrap pulse.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if ((WIDTH < 1) || (MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $fatal(1, "jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] jk_res;
  logic [WIDTH-1:0] ff_j;
  logic [WIDTH-1:0] ff_k;
  logic             direct_ok;
  logic             wrap_d;
  logic             wrap_q;

  // Value the bank would reach from the external j/k alone.
  assign jk_res    = (j & ~q) | (~k & q);
  assign direct_ok = en && !load && (mode == JK_DIRECT) && !(jk_res > MaxVal);

  always_comb begin
    nxt    = q;
    wrap_d = 1'b0;
    if (load) begin
      nxt = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      case (mode)
        JK_UP: begin
          if (q == MaxVal) begin
            nxt    = '0;
            wrap_d = 1'b1;
          end else begin
            nxt = q + WIDTH'(1);
          end
        end
        JK_DOWN: begin
          if (q == '0) begin
            nxt    = MaxVal;
            wrap_d = 1'b1;
          end else begin
            nxt = q - WIDTH'(1);
          end
        end
        JK_DIRECT: nxt = (jk_res > MaxVal) ? '0 : jk_res;
        default:   nxt = q;
      endcase
    end
  end

  // In-range direct mode passes j/k straight through; every other path
  // steers the bank to nxt.
  always_comb begin
    if (direct_ok) begin
      ff_j = j;
      ff_k = k;
    end else begin
      ff_j = nxt & ~q;
      ff_k = ~nxt & q;
    end
  end

  jk_ff_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk(clk),
    .rst(rst),
    .j  (ff_j),
    .k  (ff_k),
    .q  (q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  assign tc = !rst && en && !load &&
              (((mode == JK_UP) && (q == MaxVal)) || ((mode == JK_DOWN) && (q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10): directed
// vector table followed by random stimulus against an arithmetic model.
module tb_jk_mod_counter;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;

  int n_tests = 0;
  int n_fail  = 0;

  jk_mod_counter #(
    .WIDTH  (W),
    .MODULUS(MOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .q       (q),
    .tc      (tc),
    .wrap    (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic [1:0] mode;
    logic [3:0] j;
    logic [3:0] k;
    logic       exp_tc;   // before the edge
    logic [3:0] exp_q;    // after the edge
    logic       exp_wrap; // after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic ld, input int lv, input logic e,
                              input logic [1:0] m, input int jj, input int kk,
                              input logic etc, input int eq, input logic ew);
    vec_t v;
    v.rst = r; v.load = ld; v.load_val = 4'(lv); v.en = e; v.mode = m;
    v.j = 4'(jj); v.k = 4'(kk); v.exp_tc = etc; v.exp_q = 4'(eq); v.exp_wrap = ew;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic r, input logic ld, input logic [3:0] lv, input logic e,
                       input logic [1:0] m, input logic [3:0] jj, input logic [3:0] kk);
    rst = r; load = ld; load_val = lv; en = e; mode = m; j = jj; k = kk;
  endtask

  // Reference model state
  int m_q;
  int m_wrap;

  function automatic int model_tc(input logic r, input logic ld, input logic e,
                                  input logic [1:0] m);
    if (r || ld || !e) return 0;
    if (m == 2'b01 && m_q == MOD - 1) return 1;
    if (m == 2'b10 && m_q == 0) return 1;
    return 0;
  endfunction

  task automatic model_step(input logic r, input logic ld, input int lv, input logic e,
                            input logic [1:0] m, input logic [3:0] jj, input logic [3:0] kk);
    int res;
    m_wrap = 0;
    if (r) begin
      m_q = 0;
    end else if (ld) begin
      m_q = (lv < MOD) ? lv : MOD - 1;
    end else if (e) begin
      if (m == 2'b01) begin
        m_wrap = (m_q == MOD - 1);
        m_q    = (m_q + 1) % MOD;
      end else if (m == 2'b10) begin
        m_wrap = (m_q == 0);
        m_q    = (m_q + MOD - 1) % MOD;
      end else if (m == 2'b11) begin
        res = 0;
        for (int b = 0; b < W; b++) begin
          int bit_v;
          bit_v = (m_q >> b) & 1;
          if (jj[b] && kk[b])       bit_v = 1 - bit_v;
          else if (jj[b])           bit_v = 1;
          else if (kk[b])           bit_v = 0;
          res += bit_v << b;
        end
        m_q = (res >= MOD) ? 0 : res;
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; mode = 2'b00; j = '0; k = '0;
    m_q = 0; m_wrap = 0;

    // Reset wins over load/count
    add(1, 1, 5, 1, 2'b01, 0, 0, 0, 0, 0);
    // Up count 12 edges from 0
    for (int i = 0; i < 12; i++) begin
      add(0, 0, 0, 1, 2'b01, 0, 0, (i == 9), (i + 1) % 10, (i == 9));
    end
    // Continue to 6, then reset mid-count
    for (int i = 3; i <= 6; i++) add(0, 0, 0, 1, 2'b01, 0, 0, 0, i, 0);
    add(1, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0);
    // Down count from 0
    add(0, 0, 0, 1, 2'b10, 0, 0, 1, 9, 1);
    add(0, 0, 0, 1, 2'b10, 0, 0, 0, 8, 0);
    add(0, 0, 0, 1, 2'b10, 0, 0, 0, 7, 0);
    // Loads, clamp, load overriding a pending wrap
    add(0, 1, 7, 0, 2'b00, 0, 0, 0, 7, 0);
    add(0, 1, 12, 0, 2'b00, 0, 0, 0, 9, 0);
    add(0, 1, 3, 1, 2'b01, 0, 0, 0, 3, 0);
    add(0, 1, 9, 0, 2'b01, 0, 0, 0, 9, 0);
    add(0, 0, 0, 0, 2'b01, 0, 0, 0, 9, 0);
    add(0, 0, 0, 1, 2'b10, 0, 0, 0, 8, 0);
    // Direct JK
    add(0, 1, 1, 0, 2'b00, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 2'b11, 4'b0110, 4'b0000, 0, 7, 0);
    add(0, 0, 0, 1, 2'b11, 4'b0000, 4'b0011, 0, 4, 0);
    add(0, 0, 0, 1, 2'b11, 4'b1111, 4'b1111, 0, 0, 0);
    add(0, 1, 5, 0, 2'b00, 0, 0, 0, 5, 0);
    add(0, 0, 0, 1, 2'b11, 4'b0000, 4'b0000, 0, 5, 0);
    add(0, 0, 0, 0, 2'b11, 4'b1010, 4'b0101, 0, 5, 0);
    // Enable/hold
    add(0, 1, 3, 0, 2'b00, 0, 0, 0, 3, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 2'b01, 0, 0, 0, 3, 0);
    add(0, 0, 0, 1, 2'b00, 0, 0, 0, 3, 0);
    // Up wrap immediately followed by hold: pulse must last one cycle
    add(0, 1, 9, 0, 2'b00, 0, 0, 0, 9, 0);
    add(0, 0, 0, 1, 2'b01, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0);

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].mode,
            vecs[i].j, vecs[i].k);
      @(negedge clk);
      if (i > 0) check($sformatf("vec%0d tc", i), int'(tc), int'(vecs[i].exp_tc));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d q", i), int'(q), int'(vecs[i].exp_q));
      check($sformatf("vec%0d wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
    end

    // Random phase, model starts from the reset state
    drive(1, 0, 0, 0, 2'b00, 0, 0);
    @(posedge clk);
    #1;
    m_q = 0; m_wrap = 0;
    for (int i = 0; i < 400; i++) begin
      logic       r_rst, r_load, r_en;
      logic [1:0] r_mode;
      logic [3:0] r_lv, r_j, r_k;
      r_rst  = ($urandom_range(0, 31) == 0);
      r_load = ($urandom_range(0, 7) == 0);
      r_en   = ($urandom_range(0, 3) != 0);
      r_mode = 2'($urandom_range(0, 3));
      r_lv   = 4'($urandom_range(0, 15));
      r_j    = 4'($urandom_range(0, 15));
      r_k    = 4'($urandom_range(0, 15));
      drive(r_rst, r_load, r_lv, r_en, r_mode, r_j, r_k);
      @(negedge clk);
      if (!r_rst) check($sformatf("rnd%0d tc", i), int'(tc), model_tc(r_rst, r_load, r_en, r_mode));
      model_step(r_rst, r_load, int'(r_lv), r_en, r_mode, r_j, r_k);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d q", i), int'(q), m_q);
      check($sformatf("rnd%0d wrap", i), int'(wrap), m_wrap);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
Parametrised, clocked modulo counter whose state register is a bank of edge-triggered JK flip-flops. It supports hold, up-count, down-count and direct per-bit JK operation, plus parallel load. It outputs a terminal-count flag and a registered wrap pulse. It is the synchronous, multi-bit successor to the single-bit JK storage element and is used as a general event/sequence counter.

Parameters:
WIDTH, 4, counter width in bits (>= 1)
MODULUS, 2**WIDTH, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count/JK enable; has no effect on load
load  input  1  parallel load request
load_val  input  WIDTH  value to load
mode  input  2  00 hold, 01 up, 10 down, 11 direct JK
j  input  WIDTH  per-bit J, used only in mode 11
k  input  WIDTH  per-bit K, used only in mode 11
q  output  WIDTH  counter state, registered
tc  output  1  terminal count, combinational
wrap  output  1  one-cycle registered wrap pulse

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: on an edge with rst=1, q<=0 and wrap<=0, regardless of all other inputs. Reset mid-count aborts the count; no wrap pulse is produced.
- Priority at each edge: rst > load > (en && mode) > hold.
- load=1: q<=min(load_val, MODULUS-1) and wrap<=0. The load is applied even when en=0, and mode, j and k are ignored.
- en=0 with load=0: q holds and wrap<=0.
- en=1, mode 00: q holds and wrap<=0.
- en=1, mode 01: if q==MODULUS-1, then q<=0 and wrap<=1. Otherwise q<=q+1 and wrap<=0.
- en=1, mode 10: if q==0, then q<=MODULUS-1 and wrap<=1. Otherwise q<=q-1 and wrap<=0.
- en=1, mode 11, per bit i:
  - j=0, k=0: bit holds.
  - j=0, k=1: bit cleared.
  - j=1, k=0: bit set.
  - j=1, k=1: bit toggles.
  - If the resulting value is >= MODULUS, q<=0. wrap<=0 in this mode in all cases.
- Increment and decrement use WIDTH-bit arithmetic. Wrap is detected by comparing q against MODULUS-1 or 0, never from carry-out, so non-power-of-two moduli are exact.
- tc = en && !load && ((mode==01 && q==MODULUS-1) || (mode==10 && q==0)). tc is 0 in all other cases, including during rst.
- Latency: q and wrap update one cycle after the inputs are sampled. tc reflects the current q and inputs with zero latency.
- The counter logic drives each flip-flop's J/K as J_i = next_i & ~q_i and K_i = ~next_i & q_i. In mode 11 the bank sees the external j/k, followed by the modulus check on the result.
- Out-of-range q cannot occur after reset: every path either clamps the value or forces it to 0.
- Elaboration check: out-of-range MODULUS is a fatal error.

Decomposition:
- Shared package jk_pkg: mode encoding constants (JK_HOLD=2'b00, JK_UP=2'b01, JK_DOWN=2'b10, JK_DIRECT=2'b11).
- Sub-module jk_ff_bank #(WIDTH):
  - Ports: clk, rst, j[WIDTH], k[WIDTH], q[WIDTH].
  - Per-bit edge-triggered JK with synchronous active-high reset to 0.
  - jk_mod_counter instantiates one jk_ff_bank and contains the next-state, clamp, tc and wrap logic.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10.
1. Reset: rst=1 together with load=1, load_val=5, en=1, mode=01 -> after the edge q=0, wrap=0, tc=0. Assert rst at q=6 mid up-count -> q=0 and no wrap pulse.
2. Up count: en=1, mode=01 from q=0 for 12 edges -> q=1,2,...,9,0,1,2. tc=1 only while q=9. wrap=1 for exactly the one cycle after the 9->0 edge.
3. Down count: en=1, mode=10 from q=0 -> q=9,8,7. tc=1 while q=0. wrap=1 for one cycle after the 0->9 edge.
4. Load: load=1, load_val=7, en=0 -> q=7. load_val=12 -> q=9 (clamped). load=1 with en=1, mode=01 at q=9 -> q=load value, wrap=0, tc=0.
5. Direct JK (en=1, mode=11):
   - q=0001, j=0110, k=0000 -> q=0111.
   - q=0111, j=0000, k=0011 -> q=0100.
   - q=0100, j=1111, k=1111 -> 1011 (11 >= 10) -> q=0.
   - j=0, k=0 -> q holds.
   - wrap stays 0 throughout.
6. Enable/hold: en=0, mode=01 at q=3 for 5 edges -> q=3, tc=0, wrap=0. en=1, mode=00 -> q=3 holds.
